char_spawner: RTL and testbench

Upstream producer of falling characters for the play field. It owns a 16-bit LFSR, a spawn-interval divider and a per-slot occupancy map. Once per spawn interval it picks a random lowercase letter, speed and free column slot, then offers the spawn to the display/falling-character stage over a valid/ready handshake. It replaces free-running random generation with collision-free slot allocation; the downstream stage returns slots through `free_*` when a character is removed or reaches the bottom.

---
 rtl/game_pkg.sv | 29 ++
 rtl/lfsr16.sv | 21 ++
 rtl/char_spawner.sv | 174 +++++++++++++++++
 tb/tb_char_spawner.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types, constants and helpers for the falling-character game.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PICK,
        ST_PROBE,
        ST_OFFER
    } spawn_state_t;

    localparam logic [15:0] LFSR_MASK     = 16'hB400;
    localparam logic [7:0]  ASCII_BASE    = 8'h61;
    localparam int          LETTER_COUNT  = 26;
    localparam int          DEF_SLOT_W    = 20;
    localparam int          DEF_NUM_SLOTS = 32;

    // One Galois step: shift right, fold the mask in when a one falls out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // Scale a random byte onto 'a'..'z' without a divider: (r*26)>>8.
    function automatic logic [7:0] letter_from(input logic [7:0] r);
        logic [12:0] prod;
        prod = 13'(r) * 13'(LETTER_COUNT);
        return ASCII_BASE + {3'b000, prod[12:8]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that advances only while enabled.
module lfsr16
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // Load the seed on reset, otherwise step once per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= seed;
        end else if (en) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/char_spawner.sv
// Periodic spawner: picks a random letter, speed and free column slot and
// offers it downstream over valid/ready, tracking slot occupancy.
//
// Handshake: spawn_valid is high exactly while the FSM sits in OFFER and all
// spawn_* fields are held stable; the transfer happens on a rising edge where
// spawn_valid and spawn_ready are both high. Dropping en withdraws the offer
// without a transfer.
module char_spawner
    import game_pkg::*;
#(
    parameter int          NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int          SLOT_W    = DEF_SLOT_W,
    parameter int          X_MARGIN  = 4,
    parameter int          TICK_DIV  = 25_000_000,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         clear,
    input  logic                         free_valid,
    input  logic [$clog2(NUM_SLOTS)-1:0] free_slot,
    output logic                         spawn_valid,
    input  logic                         spawn_ready,
    output logic [7:0]                   spawn_ascii,
    output logic [2:0]                   spawn_speed,
    output logic [$clog2(NUM_SLOTS)-1:0] spawn_slot,
    output logic [9:0]                   spawn_x,
    output logic [NUM_SLOTS-1:0]         occupancy,
    output logic [$clog2(NUM_SLOTS):0]   live_count
);

    localparam int SW = $clog2(NUM_SLOTS);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [15:0]          lfsr_q;
    logic [DW-1:0]        div_q;
    logic                 tick;
    spawn_state_t         state_q, state_d;
    logic [SW-1:0]        cand_q, cand_d;
    logic [SW-1:0]        probes_q, probes_d;
    logic                 load_fields;
    logic                 load_x;
    logic                 handshake;
    logic [NUM_SLOTS-1:0] occ_q, occ_d;
    logic [7:0]           ascii_q;
    logic [2:0]           speed_q;
    logic [9:0]           x_q;
    logic                 unused_lfsr;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .seed (SEED),
        .q    (lfsr_q)
    );

    // Bit 10 sits between the speed and slot fields and is not consumed.
    assign unused_lfsr = lfsr_q[10];

    assign tick = en && (div_q == DW'(TICK_DIV - 1));

    // Spawn-interval divider, parked at zero whenever the game is not running.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // FSM and probe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cand_q   <= '0;
            probes_q <= '0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            probes_q <= probes_d;
        end
    end

    // Next state: ticks outside IDLE are dropped; a full field ends the attempt.
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        probes_d    = probes_q;
        load_fields = 1'b0;
        load_x      = 1'b0;
        handshake   = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick) state_d = ST_PICK;
                end
                ST_PICK: begin
                    cand_d      = SW'(lfsr_q[15:11]);
                    probes_d    = '0;
                    load_fields = 1'b1;
                    state_d     = ST_PROBE;
                end
                ST_PROBE: begin
                    if (!occ_q[cand_q]) begin
                        load_x  = 1'b1;
                        state_d = ST_OFFER;
                    end else if (probes_q == SW'(NUM_SLOTS - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        cand_d   = cand_q + 1'b1;
                        probes_d = probes_q + 1'b1;
                    end
                end
                ST_OFFER: begin
                    if (spawn_ready) begin
                        handshake = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Registered spawn fields: letter/speed latched in PICK, x once a slot is found.
    always_ff @(posedge clk) begin
        if (rst) begin
            ascii_q <= '0;
            speed_q <= '0;
            x_q     <= '0;
        end else begin
            if (load_fields) begin
                ascii_q <= letter_from(lfsr_q[7:0]);
                speed_q <= 3'd1 + {1'b0, lfsr_q[9:8]};
            end
            if (load_x) begin
                x_q <= 10'(int'(cand_q) * SLOT_W + X_MARGIN);
            end
        end
    end

    // Occupancy update: clear beats a handshake set, which beats a free.
    always_comb begin
        occ_d = occ_q;
        if (free_valid) occ_d[free_slot] = 1'b0;
        if (handshake)  occ_d[cand_q]    = 1'b1;
        if (clear)      occ_d            = '0;
    end

    // Occupancy map and its one-cycle-late population count.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= '0;
            live_count <= '0;
        end else begin
            occ_q      <= occ_d;
            live_count <= (SW + 1)'($countones(occ_q));
        end
    end

    assign spawn_valid = (state_q == ST_OFFER);
    assign spawn_ascii = ascii_q;
    assign spawn_speed = speed_q;
    assign spawn_slot  = cand_q;
    assign spawn_x     = x_q;
    assign occupancy   = occ_q;

endmodule

// File: tb/tb_char_spawner.sv
// Self-checking bench for char_spawner with a short spawn interval.
module tb_char_spawner;
    import game_pkg::*;

    localparam int          TICK_DIV = 8;
    localparam int          NSLOT    = 32;
    localparam logic [15:0] SEED_V   = 16'hACE1;
    localparam int          W        = 26;

    typedef struct {
        int stall;
        bit hs_free;
        bit hs_clear;
        int mode;
        int exp_live;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       clear = 1'b0;
    logic       free_valid = 1'b0;
    logic [4:0] free_slot = '0;
    logic       spawn_valid;
    logic       spawn_ready = 1'b0;
    logic [7:0] spawn_ascii;
    logic [2:0] spawn_speed;
    logic [4:0] spawn_slot;
    logic [9:0] spawn_x;
    logic [31:0] occupancy;
    logic [5:0] live_count;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0] m_occ = '0;
    logic [15:0] m_lfsr;
    logic [4:0]  last_slot;
    logic [9:0]  last_x;
    vec_t vecs[8];

    char_spawner #(.TICK_DIV(TICK_DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .clear       (clear),
        .free_valid  (free_valid),
        .free_slot   (free_slot),
        .spawn_valid (spawn_valid),
        .spawn_ready (spawn_ready),
        .spawn_ascii (spawn_ascii),
        .spawn_speed (spawn_speed),
        .spawn_slot  (spawn_slot),
        .spawn_x     (spawn_x),
        .occupancy   (occupancy),
        .live_count  (live_count)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    // Reference LFSR: x^16+x^14+x^13+x^11+1, Galois, steps on enabled cycles.
    function automatic logic [15:0] ref_step(input logic [15:0] q);
        logic [15:0] r;
        r = q >> 1;
        if (q[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) m_lfsr <= SEED_V;
        else if (en) m_lfsr <= ref_step(m_lfsr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic free_one(input int s);
        @(posedge clk); #1;
        free_valid = 1'b1;
        free_slot  = 5'(s);
        m_occ[s]   = 1'b0;
        @(posedge clk); #1;
        free_valid = 1'b0;
        @(negedge clk);
        check("occ_after_free", occupancy, m_occ);
    endtask

    // One spawn attempt. mode 0: handshake, 1: drop en mid-offer, 2: reset mid-offer.
    task automatic run_attempt(input int stall, input bit hs_free, input bit hs_clear,
                               input int mode, input bit from_reset);
        logic [15:0] l;
        int          prod;
        logic [7:0]  e_ascii;
        logic [2:0]  e_speed;
        logic [4:0]  cand;
        logic [4:0]  e_slot;
        int          k;
        bit          found;
        bit          seen;
        int          n;
        int          bad;
        logic [W-1:0] exp_w;
        logic [W-1:0] act_w;

        @(posedge clk); #1;
        if (from_reset) rst = 1'b0;
        else en = 1'b1;

        l = m_lfsr;
        for (int i = 0; i < TICK_DIV; i++) l = ref_step(l);
        prod    = int'(l[7:0]) * 26;
        e_ascii = 8'h61 + 8'(prod / 256);
        e_speed = 3'd1 + 3'(l[9:8]);
        cand    = l[15:11];
        found   = 1'b0;
        k       = 0;
        e_slot  = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (!found && !m_occ[5'(int'(cand) + i)]) begin
                found  = 1'b1;
                k      = i;
                e_slot = 5'(int'(cand) + i);
            end
        end

        if (!found) begin
            bad = 0;
            for (int i = 0; i <= TICK_DIV + 1 + NSLOT; i++) begin
                @(negedge clk);
                if (spawn_valid) bad++;
                if (i == TICK_DIV + NSLOT)
                    check("probe_last_cycle", 32'(dut.state_q), 32'(ST_PROBE));
                if (i == TICK_DIV + 1 + NSLOT)
                    check("idle_after_full", 32'(dut.state_q), 32'(ST_IDLE));
            end
            check("no_offer_when_full", bad, 0);
            check("live_full", 32'(live_count), NSLOT);
            @(posedge clk); #1;
            en = 1'b0;
            return;
        end

        exp_q.push_back({e_ascii, e_speed, e_slot, 10'(int'(e_slot) * 20 + 4)});

        n = 0;
        seen = 1'b0;
        while (n < TICK_DIV + NSLOT + 6) begin
            @(negedge clk);
            if (spawn_valid) begin
                seen = 1'b1;
                break;
            end
            n++;
        end
        check("offer_seen", 32'(seen), 1);
        exp_w = exp_q.pop_front();
        if (!seen) begin
            en = 1'b0;
            return;
        end
        check("offer_latency", n, TICK_DIV + 2 + k);
        act_w = {spawn_ascii, spawn_speed, spawn_slot, spawn_x};
        check("offer_fields", 32'(act_w), 32'(exp_w));
        last_slot = spawn_slot;
        last_x    = spawn_x;

        bad = 0;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            act_w = {spawn_ascii, spawn_speed, spawn_slot, spawn_x};
            if (!spawn_valid || act_w !== exp_w) bad++;
        end
        if (stall > 0) check("offer_stable", bad, 0);

        case (mode)
            0: begin
                spawn_ready = 1'b1;
                if (hs_free) begin
                    free_valid = 1'b1;
                    free_slot  = e_slot;
                end
                if (hs_clear) clear = 1'b1;
                if (hs_clear) m_occ = '0;
                else m_occ[e_slot] = 1'b1;
            end
            1: en = 1'b0;
            default: begin
                rst   = 1'b1;
                m_occ = '0;
            end
        endcase

        @(posedge clk); #1;
        spawn_ready = 1'b0;
        free_valid  = 1'b0;
        clear       = 1'b0;
        en          = 1'b0;
        @(negedge clk);
        check("valid_after_offer", 32'(spawn_valid), 0);
        check("occ_after_offer", occupancy, m_occ);
        @(negedge clk);
        check("live_after_offer", 32'(live_count), $countones(m_occ));
    endtask

    initial begin
        vecs[0] = '{stall: 0,  hs_free: 1'b0, hs_clear: 1'b0, mode: 0, exp_live: 2};
        vecs[1] = '{stall: 3,  hs_free: 1'b0, hs_clear: 1'b0, mode: 0, exp_live: 3};
        vecs[2] = '{stall: 20, hs_free: 1'b0, hs_clear: 1'b0, mode: 0, exp_live: 4};
        vecs[3] = '{stall: 0,  hs_free: 1'b1, hs_clear: 1'b0, mode: 0, exp_live: 5};
        vecs[4] = '{stall: 2,  hs_free: 1'b0, hs_clear: 1'b0, mode: 1, exp_live: 5};
        vecs[5] = '{stall: 0,  hs_free: 1'b0, hs_clear: 1'b0, mode: 0, exp_live: 6};
        vecs[6] = '{stall: 1,  hs_free: 1'b0, hs_clear: 1'b1, mode: 0, exp_live: 0};
        vecs[7] = '{stall: 0,  hs_free: 1'b0, hs_clear: 1'b0, mode: 0, exp_live: 1};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(spawn_valid), 0);
        check("rst_ascii", 32'(spawn_ascii), 0);
        check("rst_speed", 32'(spawn_speed), 0);
        check("rst_slot",  32'(spawn_slot), 0);
        check("rst_x",     32'(spawn_x), 0);
        check("rst_occ",   occupancy, 0);
        check("rst_live",  32'(live_count), 0);

        // First spawn straight out of reset with en held high.
        run_attempt(0, 1'b0, 1'b0, 0, 1'b1);
        check("first_live", 32'(live_count), 1);

        // Table of handshake variants.
        for (int v = 0; v < 8; v++) begin
            run_attempt(vecs[v].stall, vecs[v].hs_free, vecs[v].hs_clear, vecs[v].mode, 1'b0);
            check("vec_live", 32'(live_count), vecs[v].exp_live);
        end

        // Fill the field; later spawns have to probe past occupied slots.
        while ($countones(m_occ) < NSLOT) run_attempt(0, 1'b0, 1'b0, 0, 1'b0);
        check("filled_occ", occupancy, 32'hFFFF_FFFF);

        // Full field: attempt runs out of probes with no offer.
        run_attempt(0, 1'b0, 1'b0, 0, 1'b0);

        // Only slot 8 free: allocation must land there.
        free_one(8);
        run_attempt(0, 1'b0, 1'b0, 0, 1'b0);
        check("slot8_slot", 32'(last_slot), 8);
        check("slot8_x", 32'(last_x), 164);

        // Freeing an already-free slot changes nothing.
        free_one(10);
        free_one(10);
        @(negedge clk);
        check("double_free_live", 32'(live_count), 31);

        // Reset while offering.
        run_attempt(3, 1'b0, 1'b0, 2, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
